// File: rtl/trace_pkg.sv
// Shared types for the trace capture block.
// Record layout, serializer states and word formatting.
package trace_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    PC,
    INST,
    RW,
    R1,
    R2
  } ser_state_e;

  localparam logic [7:0] HDR_MAGIC = 8'hA5;

  typedef struct packed {
    logic [15:0] seq;
    logic        flag;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] rw;
    logic [31:0] r1;
    logic [31:0] r2;
  } trace_rec_t;

  function automatic logic [31:0] rec_word(
    ser_state_e s,
    trace_rec_t r
  );
    unique case (s)
      HDR:     return {HDR_MAGIC, r.seq, 7'b0, r.flag};
      PC:      return r.pc;
      INST:    return r.inst;
      RW:      return r.rw;
      R1:      return r.r1;
      R2:      return r.r2;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous record FIFO for trace_capture.
// Head entry is visible on dout_o whenever non-empty.
module trace_fifo
  import trace_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  trace_rec_t    din_i,
  input  logic          pop_i,
  output trace_rec_t    dout_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  trace_rec_t    mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [CW-1:0] cnt_q;
  logic          do_push;
  logic          do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rd_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/trace_capture.sv
// Samples TOP observation outputs into records and streams
// each record as six 32-bit words over valid/ready.
module trace_capture
  import trace_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int SEQ_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        capture_en,
  input  logic [31:0] pc_in,
  input  logic [31:0] inst_in,
  input  logic [31:0] rw_in,
  input  logic [31:0] r1_in,
  input  logic [31:0] r2_in,
  input  logic        flag_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        overflow,
  output logic [7:0]  drop_count
);

  localparam int CW = $clog2(DEPTH) + 1;

  trace_rec_t       rec;
  trace_rec_t       head;
  trace_rec_t       hold_q, hold_d;
  ser_state_e       state_q, state_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic [31:0]      data_q, data_d;
  logic [SEQ_W-1:0] seq_q;
  logic             ovf_q;
  logic [7:0]       drop_q;
  logic             push, pop, full, empty;
  logic             hs, r2_done, room;
  logic [CW-1:0]    count;
  logic [CW:0]      occ;

  assign hs      = valid_q && out_ready;
  assign r2_done = (state_q == R2) && hs;
  assign pop     = !empty && ((state_q == IDLE) || r2_done);

  // The holding register counts toward capacity; it frees at R2.
  assign occ  = {1'b0, count} + {{CW{1'b0}}, state_q != IDLE};
  assign room = (occ < (CW+1)'(DEPTH)) || r2_done;
  assign push = capture_en && room && (!full || pop);

  always_comb begin
    rec                = '0;
    rec.seq[SEQ_W-1:0] = seq_q;
    rec.flag           = flag_in;
    rec.pc             = pc_in;
    rec.inst           = inst_in;
    rec.rw             = rw_in;
    rec.r1             = r1_in;
    rec.r2             = r2_in;
  end

  trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   (rec),
    .pop_i   (pop),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    valid_d = valid_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: if (pop) begin
        hold_d  = head;
        state_d = HDR;
        valid_d = 1'b1;
      end
      HDR:  if (hs) state_d = PC;
      PC:   if (hs) state_d = INST;
      INST: if (hs) state_d = RW;
      RW:   if (hs) state_d = R1;
      R1:   if (hs) begin
        state_d = R2;
        last_d  = 1'b1;
      end
      R2:   if (hs) begin
        last_d = 1'b0;
        if (pop) begin
          hold_d  = head;
          state_d = HDR;
        end else begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    data_d = rec_word(state_d, hold_d);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      hold_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
      seq_q   <= '0;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      data_q  <= data_d;
      if (push) seq_q <= seq_q + 1'b1;
      if (capture_en && !push) begin
        ovf_q <= 1'b1;
        if (drop_q != 8'hFF) drop_q <= drop_q + 1'b1;
      end
    end
  end

  assign out_valid  = valid_q;
  assign out_data   = data_q;
  assign out_last   = last_q;
  assign overflow   = ovf_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_trace_capture.sv
// Randomized bench for trace_capture with a record-level
// scoreboard of expected words, drops and overflow.
module tb_trace_capture;

  localparam int DEPTH = 8;
  localparam int SEQ_W = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        capture_en = 1'b0;
  logic [31:0] pc_in = '0;
  logic [31:0] inst_in = '0;
  logic [31:0] rw_in = '0;
  logic [31:0] r1_in = '0;
  logic [31:0] r2_in = '0;
  logic        flag_in = 1'b0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_last;
  logic        overflow;
  logic [7:0]  drop_count;

  always #5 clk = ~clk;

  trace_capture #(.DEPTH(DEPTH), .SEQ_W(SEQ_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .capture_en (capture_en),
    .pc_in      (pc_in),
    .inst_in    (inst_in),
    .rw_in      (rw_in),
    .r1_in      (r1_in),
    .r2_in      (r2_in),
    .flag_in    (flag_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  logic [31:0] exp_q[$];
  int          accepted, completed, wi, drop_m, seq_m;
  logic        ovf_m, stall;
  logic [31:0] sdata, last_hdr, prev_hdr;

  task automatic model_clear();
    exp_q.delete();
    accepted  = 0;
    completed = 0;
    wi        = 0;
    drop_m    = 0;
    seq_m     = 0;
    ovf_m     = 1'b0;
    stall     = 1'b0;
    last_hdr  = '0;
    prev_hdr  = '0;
  endtask

  always @(posedge clk) begin
    logic        hs, r2hs;
    logic [31:0] w;
    if (!rst) begin
      stall = 1'b0;
    end else begin
      if (stall) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_data", out_data, sdata);
      end
      stall = out_valid && !out_ready;
      sdata = out_data;
      chk("overflow", 32'(overflow), 32'(ovf_m));
      chk("drop_count", 32'(drop_count), 32'(drop_m));
      hs   = out_valid && out_ready;
      r2hs = 1'b0;
      if (hs) begin
        if (exp_q.size() == 0) begin
          chk("spurious_word", 32'(out_valid), 32'd0);
        end else begin
          w = exp_q.pop_front();
          chk("word", out_data, w);
          chk("last", 32'(out_last), 32'(wi % 6 == 5));
          if (wi % 6 == 0) begin
            prev_hdr = last_hdr;
            last_hdr = out_data;
          end
          r2hs = (wi % 6 == 5);
          wi++;
        end
      end
      if (capture_en) begin
        if ((accepted - completed) < DEPTH || r2hs) begin
          exp_q.push_back({8'hA5, 16'(seq_m), 7'b0, flag_in});
          exp_q.push_back(pc_in);
          exp_q.push_back(inst_in);
          exp_q.push_back(rw_in);
          exp_q.push_back(r1_in);
          exp_q.push_back(r2_in);
          seq_m = (seq_m + 1) % (1 << SEQ_W);
          accepted++;
        end else begin
          ovf_m = 1'b1;
          if (drop_m < 255) drop_m++;
        end
      end
      if (r2hs) completed++;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic rand_inputs();
    pc_in   = $urandom;
    inst_in = $urandom;
    rw_in   = $urandom;
    r1_in   = $urandom;
    r2_in   = $urandom;
    flag_in = 1'($urandom);
  endtask

  task automatic drain(string tag, bit rnd_ready);
    for (int i = 0; i < 3000; i++) begin
      if (exp_q.size() == 0 && !out_valid) break;
      out_ready = rnd_ready ? 1'($urandom) : 1'b1;
      @(negedge clk);
    end
    chk(tag, exp_q.size(), 0);
  endtask

  logic [31:0] t2w[6];
  int nv, first_i, last_i;

  initial begin
    model_clear();
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_drop", 32'(drop_count), 32'd0);
    do_reset();

    // single capture, latency and word contents
    t2w = '{32'hA5000001, 32'h00000004, 32'h8C220000, 32'd1, 32'd2, 32'd3};
    out_ready  = 1'b1;
    pc_in      = 32'h00000004;
    inst_in    = 32'h8C220000;
    rw_in      = 32'd1;
    r1_in      = 32'd2;
    r2_in      = 32'd3;
    flag_in    = 1'b1;
    capture_en = 1'b1;
    @(negedge clk);
    capture_en = 1'b0;
    chk("t2_lat_early", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("t2_lat_valid", 32'(out_valid), 32'd1);
    for (int k = 0; k < 6; k++) begin
      chk("t2_word", out_data, t2w[k]);
      chk("t2_last", 32'(out_last), 32'(k == 5));
      @(negedge clk);
    end
    chk("t2_idle", 32'(out_valid), 32'd0);
    drain("t2_drain", 1'b0);

    // three back-to-back captures, no bubbles
    do_reset();
    out_ready = 1'b1;
    nv = 0;
    first_i = -1;
    last_i = -1;
    for (int i = 0; i < 40; i++) begin
      capture_en = (i < 3);
      rand_inputs();
      @(negedge clk);
      if (out_valid) begin
        nv++;
        if (first_i < 0) first_i = i;
        last_i = i;
      end
    end
    capture_en = 1'b0;
    chk("t3_words", nv, 18);
    chk("t3_gaps", last_i - first_i + 1, 18);
    chk("t3_seq2", last_hdr[23:8], 2);
    drain("t3_drain", 1'b0);

    // overflow with consumer stalled
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      capture_en = 1'b1;
      rand_inputs();
      @(negedge clk);
    end
    capture_en = 1'b0;
    chk("t4_ovf", 32'(overflow), 32'd1);
    chk("t4_drop", 32'(drop_count), 32'd2);
    drain("t4_drain", 1'b0);
    chk("t4_records", completed, 8);
    chk("t4_last_seq", last_hdr[23:8], 7);

    // reset during the PC word
    do_reset();
    out_ready  = 1'b1;
    capture_en = 1'b1;
    rand_inputs();
    @(negedge clk);
    capture_en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid && wi == 1) break;
      @(negedge clk);
    end
    chk("t1_reach_pc", wi, 1);
    rst = 1'b0;
    #1;
    chk("t1_valid", 32'(out_valid), 32'd0);
    chk("t1_data", out_data, 32'd0);
    chk("t1_last", 32'(out_last), 32'd0);
    chk("t1_ovf", 32'(overflow), 32'd0);
    chk("t1_drop", 32'(drop_count), 32'd0);
    model_clear();
    @(negedge clk);
    rst = 1'b1;
    capture_en = 1'b1;
    rand_inputs();
    flag_in = 1'b0;
    @(negedge clk);
    capture_en = 1'b0;
    @(negedge clk);
    chk("t1_hdr_seq0", out_data, 32'hA5000000);
    drain("t1_drain", 1'b0);

    // random capture and random back-pressure
    do_reset();
    for (int i = 0; i < 400; i++) begin
      capture_en = ($urandom_range(2) == 0);
      out_ready  = 1'($urandom);
      rand_inputs();
      @(negedge clk);
    end
    capture_en = 1'b0;
    drain("t5_drain", 1'b1);

    // sequence wrap at 2^SEQ_W
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < (1 << SEQ_W) + 1; i++) begin
      capture_en = 1'b1;
      rand_inputs();
      flag_in = 1'b0;
      @(negedge clk);
      capture_en = 1'b0;
      repeat (7) @(negedge clk);
    end
    drain("t6_drain", 1'b0);
    chk("t6_hdr_max", prev_hdr, {8'hA5, 16'((1 << SEQ_W) - 1), 8'h00});
    chk("t6_hdr_wrap", last_hdr, 32'hA5000000);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
